// File: rtl/logic_seq_pkg.sv
// logic_seq_pkg
//   Shared constants for the logic-unit sequencer:
//   - logic-unit op codes (3-bit, as issued on lu_op)
//   - extended compound request codes (4-bit, as received on in_op)
//   - sequencer FSM state encodings
package logic_seq_pkg;

  // Logic-unit primitive op codes
  localparam logic [2:0] LU_CLR  = 3'd0;
  localparam logic [2:0] LU_NOT  = 3'd1;
  localparam logic [2:0] LU_XOR  = 3'd2;
  localparam logic [2:0] LU_AND  = 3'd3;
  localparam logic [2:0] LU_PASS = 3'd4;
  localparam logic [2:0] LU_OR   = 3'd5;
  localparam logic [2:0] LU_ONES = 3'd6;

  // Compound request codes, each built from two logic-unit passes
  localparam logic [3:0] SEQ_NAND = 4'd8;
  localparam logic [3:0] SEQ_NOR  = 4'd9;
  localparam logic [3:0] SEQ_XNOR = 4'd10;
  localparam logic [3:0] SEQ_ANDN = 4'd11;

  // Sequencer FSM states
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_EXEC1 = 3'd1;
  localparam logic [2:0] ST_EXEC2 = 3'd2;
  localparam logic [2:0] ST_CAPT  = 3'd3;
  localparam logic [2:0] ST_RESP  = 3'd4;

endpackage

// File: rtl/logic_seq_decode.sv
// logic_seq_decode
//   Combinational request decoder: maps a 4-bit request code onto one or
//   two logic-unit passes.
// Ports
//   op       in   4  request code
//   illegal  out  1  code has no mapping (7, 12..15)
//   twoPass  out  1  compound op, needs a second pass
//   op1      out  3  logic-unit op for pass 1
//   op2      out  3  logic-unit op for pass 2 (only meaningful if twoPass)
module logic_seq_decode
  import logic_seq_pkg::*;
(
  input  logic [3:0] op,
  output logic       illegal,
  output logic       twoPass,
  output logic [2:0] op1,
  output logic [2:0] op2
);

  always_comb begin
    illegal = 1'b0;
    twoPass = 1'b0;
    op1     = LU_CLR;
    op2     = LU_CLR;
    case (op)
      {1'b0, LU_CLR}, {1'b0, LU_NOT}, {1'b0, LU_XOR}, {1'b0, LU_AND},
      {1'b0, LU_PASS}, {1'b0, LU_OR}, {1'b0, LU_ONES}: begin
        op1 = op[2:0];
      end
      // Pass 2 always works on the pass-1 result fed back as RhsIn.
      SEQ_NAND: begin twoPass = 1'b1; op1 = LU_AND; op2 = LU_NOT; end
      SEQ_NOR:  begin twoPass = 1'b1; op1 = LU_OR;  op2 = LU_NOT; end
      SEQ_XNOR: begin twoPass = 1'b1; op1 = LU_XOR; op2 = LU_NOT; end
      // ANDN: t = ~rhs, then lhs & t
      SEQ_ANDN: begin twoPass = 1'b1; op1 = LU_NOT; op2 = LU_AND; end
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/logic_seq.sv
// logic_seq
//   Sequencer in front of the 1-cycle registered logic unit. Accepts
//   primitive (0..6) and compound (NAND/NOR/XNOR/ANDN) requests over
//   valid/ready, issues one or two logic-unit passes and returns the result
//   over valid/ready. Illegal codes return out_err=1 with out_data=0 and
//   issue no logic-unit pass. One request in flight at a time.
// Configuration
//   LOGIC_SEQ_B2B_EN  when defined, in_ready is also high in RESP while
//                     out_ready=1, so a new request can be accepted on the
//                     same edge the previous result is handed off.
// Ports
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   request handshake; in_op, in_lhs, in_rhs payload
//   lu_op/lu_lhs/lu_rhs drive to the logic unit (zero when no pass issued)
//   lu_result           logic-unit result, valid one cycle after drive
//   out_valid/out_ready result handshake; out_data, out_err payload
//   busy                FSM not idle
module logic_seq
  import logic_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_op,
  input  logic [DATA_WIDTH-1:0] in_lhs,
  input  logic [DATA_WIDTH-1:0] in_rhs,
  output logic [2:0]            lu_op,
  output logic [DATA_WIDTH-1:0] lu_lhs,
  output logic [DATA_WIDTH-1:0] lu_rhs,
  input  logic [DATA_WIDTH-1:0] lu_result,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_err,
  output logic                  busy
);

  logic [2:0]            state;
  logic                  decIllegal;
  logic                  decTwoPass;
  logic [2:0]            decOp1;
  logic [2:0]            decOp2;
  logic                  twoPassR;
  logic [2:0]            op1R;
  logic [2:0]            op2R;
  logic [DATA_WIDTH-1:0] lhsR;
  logic [DATA_WIDTH-1:0] rhsR;
  logic                  outValidR;
  logic [DATA_WIDTH-1:0] outDataR;
  logic                  outErrR;
  logic                  accept;

  logic_seq_decode uDecode (
    .op      (in_op),
    .illegal (decIllegal),
    .twoPass (decTwoPass),
    .op1     (decOp1),
    .op2     (decOp2)
  );

  always_comb begin
`ifdef LOGIC_SEQ_B2B_EN
    in_ready = !rst && ((state == ST_IDLE) || ((state == ST_RESP) && out_ready));
`else
    in_ready = !rst && (state == ST_IDLE);
`endif
  end

  assign accept = in_valid && in_ready;

  // Captured request: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      twoPassR <= decTwoPass;
      op1R     <= decOp1;
      op2R     <= decOp2;
      lhsR     <= in_lhs;
      rhsR     <= in_rhs;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      outValidR <= 1'b0;
      outDataR  <= '0;
      outErrR   <= 1'b0;
    end else begin
      case (state)
        ST_EXEC1: state <= twoPassR ? ST_EXEC2 : ST_CAPT;
        ST_EXEC2: state <= ST_CAPT;
        ST_CAPT: begin
          outDataR  <= lu_result;
          outErrR   <= 1'b0;
          outValidR <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (out_ready) begin
            outValidR <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
      // Accept is only possible in IDLE, or in RESP on the hand-off edge
      // when back-to-back issue is enabled; it overrides the moves above.
      if (accept) begin
        if (decIllegal) begin
          outDataR  <= '0;
          outErrR   <= 1'b1;
          outValidR <= 1'b1;
          state     <= ST_RESP;
        end else begin
          state <= ST_EXEC1;
        end
      end
    end
  end

  // Logic-unit drive: pass 2 feeds the pass-1 result straight back as RhsIn.
  always_comb begin
    lu_op  = LU_CLR;
    lu_lhs = '0;
    lu_rhs = '0;
    case (state)
      ST_EXEC1: begin
        lu_op  = op1R;
        lu_lhs = lhsR;
        lu_rhs = rhsR;
      end
      ST_EXEC2: begin
        lu_op  = op2R;
        lu_lhs = lhsR;
        lu_rhs = lu_result;
      end
      default: ;
    endcase
  end

  assign out_valid = outValidR;
  assign out_data  = outDataR;
  assign out_err   = outErrR;
  assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_logic_seq.sv
// tb_logic_seq
//   Bench for logic_seq with a behavioural 1-cycle registered logic unit.
//   Directed cases, reset abort, backpressure, then random requests checked
//   against a reference computed directly from the op definitions.
module tb_logic_seq;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_op;
  logic [DW-1:0] in_lhs;
  logic [DW-1:0] in_rhs;
  logic [2:0]    lu_op;
  logic [DW-1:0] lu_lhs;
  logic [DW-1:0] lu_rhs;
  logic [DW-1:0] lu_result;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_err;
  logic          busy;

  int nTests = 0;
  int nFail  = 0;

  always #5 clk = ~clk;

  logic_seq #(.DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_lhs    (in_lhs),
    .in_rhs    (in_rhs),
    .lu_op     (lu_op),
    .lu_lhs    (lu_lhs),
    .lu_rhs    (lu_rhs),
    .lu_result (lu_result),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .busy      (busy)
  );

  // Behavioural logic unit: registered, result one cycle after drive.
  always @(posedge clk) begin
    case (lu_op)
      3'd0:    lu_result <= '0;
      3'd1:    lu_result <= ~lu_rhs;
      3'd2:    lu_result <= lu_lhs ^ lu_rhs;
      3'd3:    lu_result <= lu_lhs & lu_rhs;
      3'd4:    lu_result <= lu_rhs;
      3'd5:    lu_result <= lu_lhs | lu_rhs;
      default: lu_result <= '1;
    endcase
  end

  task automatic chkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: {err, data} of a whole request.
  function automatic logic [DW:0] refOp(input logic [3:0] op, input logic [DW-1:0] l, input logic [DW-1:0] r);
    case (op)
      4'd0:    return {1'b0, {DW{1'b0}}};
      4'd1:    return {1'b0, ~r};
      4'd2:    return {1'b0, l ^ r};
      4'd3:    return {1'b0, l & r};
      4'd4:    return {1'b0, r};
      4'd5:    return {1'b0, l | r};
      4'd6:    return {1'b0, {DW{1'b1}}};
      4'd8:    return {1'b0, ~(l & r)};
      4'd9:    return {1'b0, ~(l | r)};
      4'd10:   return {1'b0, ~(l ^ r)};
      4'd11:   return {1'b0, l & ~r};
      default: return {1'b1, {DW{1'b0}}};
    endcase
  endfunction

  function automatic int refLat(input logic [3:0] op);
    if (op == 4'd7 || op >= 4'd12) return 1;
    if (op >= 4'd8) return 4;
    return 3;
  endfunction

  // One request from IDLE through hand-off; stall = cycles of out_ready=0
  // after out_valid rises.
  task automatic runOp(input logic [3:0] op, input logic [DW-1:0] l, input logic [DW-1:0] r, input int stall);
    logic [DW:0]   exp;
    logic [DW-1:0] held;
    int            lat;
    int            w;
    exp = refOp(op, l, r);
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chkVal("in_ready_idle", {31'd0, in_ready}, 32'd1);
    in_valid  = 1'b1;
    in_op     = op;
    in_lhs    = l;
    in_rhs    = r;
    out_ready = 1'($urandom_range(0, 1));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_op    = 4'($urandom);
    in_lhs   = DW'($urandom);
    in_rhs   = DW'($urandom);
    if (exp[DW]) chkVal("illegal_lu_op", {29'd0, lu_op}, 32'd0);
    lat = 1;
    while (!out_valid && lat < 20) begin
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      lat++;
    end
    out_ready = 1'b0;
    chkVal($sformatf("latency op%0d", op), lat, refLat(op));
    chkVal($sformatf("data op%0d", op), {16'd0, out_data}, {16'd0, exp[DW-1:0]});
    chkVal($sformatf("err op%0d", op), {31'd0, out_err}, {31'd0, exp[DW]});
    if (stall > 0) begin
      held     = out_data;
      in_valid = 1'b1;
      repeat (stall) @(negedge clk);
      chkVal("stall_valid", {31'd0, out_valid}, 32'd1);
      chkVal("stall_data", {16'd0, out_data}, {16'd0, held});
      chkVal("stall_in_ready", {31'd0, in_ready}, 32'd0);
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chkVal("handoff_valid", {31'd0, out_valid}, 32'd0);
    chkVal("handoff_busy", {31'd0, busy}, 32'd0);
    out_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [DW-1:0] bD[2];
    int            bT[2];
    int            n;
    int            k;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_op     = '0;
    in_lhs    = '0;
    in_rhs    = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chkVal("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chkVal("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chkVal("rst_out_data", {16'd0, out_data}, 32'd0);
    chkVal("rst_out_err", {31'd0, out_err}, 32'd0);
    chkVal("rst_busy", {31'd0, busy}, 32'd0);
    chkVal("rst_lu_op", {29'd0, lu_op}, 32'd0);
    chkVal("rst_lu_lhs", {16'd0, lu_lhs}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases
    runOp(4'd2,  16'h00FF, 16'h0F0F, 0);
    runOp(4'd8,  16'hF0F0, 16'hFF00, 0);
    runOp(4'd11, 16'hFFFF, 16'h00F0, 0);
    runOp(4'd9,  16'h1234, 16'h4321, 0);
    runOp(4'd10, 16'hA5A5, 16'h0FF0, 2);
    runOp(4'd6,  16'h1234, 16'h5678, 0);
    runOp(4'd7,  16'hFFFF, 16'hFFFF, 0);
    runOp(4'd2,  16'h1357, 16'h2468, 5);
    runOp(4'd15, 16'h0001, 16'h0002, 3);

    // Reset during pass 2 of a NAND drops the request.
    in_valid = 1'b1;
    in_op    = 4'd8;
    in_lhs   = 16'hF0F0;
    in_rhs   = 16'hFF00;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chkVal("exec2_lu_op", {29'd0, lu_op}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chkVal("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chkVal("abort_busy", {31'd0, busy}, 32'd0);
    chkVal("abort_in_ready", {31'd0, in_ready}, 32'd1);
    chkVal("abort_lu_op", {29'd0, lu_op}, 32'd0);
    runOp(4'd2, 16'h00FF, 16'h0F0F, 0);

    // Random requests
    for (int i = 0; i < 30; i++) begin
      runOp(4'($urandom_range(0, 15)), DW'($urandom), DW'($urandom), int'($urandom_range(0, 3)));
    end

`ifdef LOGIC_SEQ_B2B_EN
    // Two XORs back to back with out_ready held high.
    n = 0;
    k = 0;
    bD[0] = '0;
    bD[1] = '0;
    bT[0] = 0;
    bT[1] = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 30 && n < 2; i++) begin
      @(negedge clk);
      if (out_valid && n < 2) begin
        bD[n] = out_data;
        bT[n] = i;
        n++;
      end
      if (k < 2) begin
        in_valid = 1'b1;
        in_op    = 4'd2;
        in_lhs   = (k == 0) ? 16'h00FF : 16'hAAAA;
        in_rhs   = (k == 0) ? 16'h0F0F : 16'h5555;
        if (in_ready) k++;
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    chkVal("b2b_count", n, 2);
    chkVal("b2b_data0", {16'd0, bD[0]}, {16'd0, refOp(4'd2, 16'h00FF, 16'h0F0F)});
    chkVal("b2b_data1", {16'd0, bD[1]}, {16'd0, refOp(4'd2, 16'hAAAA, 16'h5555)});
    chkVal("b2b_gap", bT[1] - bT[0], 3);
`else
    n = 0;
    k = 0;
    bD[0] = '0;
    bT[0] = 0;
`endif

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
